// File: rtl/tt_um_serial_add_seq.sv
// Bit-serial 8-bit adder for the TinyTapeout tile.
// Two operands are captured from ui_in under strobe control. They are then
// added LSB-first through a single full-adder cell, one bit per clock. The
// sum and carry stay on the pins until the consumer acknowledges.
//
// state | meaning
// IDLE  | accepting operand loads; start launches a run once both are loaded
// SHIFT | one full-adder step per cycle, LSB first, strobes ignored
// DONE  | result and carry held on the pins until an ack event
module tt_um_serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       sync1, sync2, sync2_d;
  logic [3:0]       strobe_ev;
  logic             ev_load_a, ev_load_b, ev_start, ev_ack;
  logic [WIDTH-1:0] a_q, b_q, sum_sr, result_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, carry_q, a_ok, b_ok;
  logic             bit_s, bit_c, last_bit, launch;
  logic             busy, done;
  logic             unused_ok;

  // ena and the upper strobe pins carry no function on this tile
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  // Two-flop synchronizer per strobe plus a delayed copy for 0->1 detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
    end else begin
      sync1   <= uio_in[3:0];
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign strobe_ev = sync2 & ~sync2_d;
  assign ev_load_a = strobe_ev[0];
  assign ev_load_b = strobe_ev[1];
  assign ev_start  = strobe_ev[2];
  assign ev_ack    = strobe_ev[3];

  // Full-adder cell fed from the operand LSBs and the running carry
  assign bit_s    = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last_bit = (cnt_q == LAST);

  // Start only counts if both operands were loaded before this edge
  assign launch = ev_start & a_ok & b_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ack in DONE takes priority over a coincident start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch)   state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (ev_ack)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture, serial add datapath and result hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_sr   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
      a_ok     <= 1'b0;
      b_ok     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_load_a) begin
            a_q  <= ui_in[WIDTH-1:0];
            a_ok <= 1'b1;
          end
          if (ev_load_b) begin
            b_q  <= ui_in[WIDTH-1:0];
            b_ok <= 1'b1;
          end
          if (launch) begin
            cnt_q <= '0;
            c_q   <= 1'b0;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          c_q    <= bit_c;
          sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            result_q <= {bit_s, sum_sr[WIDTH-1:1]};
            carry_q  <= bit_c;
          end
        end
        DONE: begin
          if (ev_ack) begin
            a_ok <= 1'b0;
            b_ok <= 1'b0;
          end
        end
        default: begin
          a_ok <= 1'b0;
          b_ok <= 1'b0;
        end
      endcase
    end
  end

  assign uo_out  = result_q;
  assign uio_out = {a_ok & b_ok, carry_q, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
